// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix stream reader: default matrix size,
// address width and the reader FSM state encoding.
package matrix_pkg;

  localparam int MAT_DIM    = 10;
  localparam int MAT_ADDR_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    HOLD,
    DONE
  } state_t;

endpackage

// File: rtl/matrix_addr_counter.sv
// Row/column index counter for the matrix scan. Wraps within 0..DIM-1.
// Build option: MATRIX_COLMAJOR_EN selects column-major advance
// (row first); otherwise the index advances row-major (column first).
import matrix_pkg::*;

module matrix_addr_counter #(
  parameter int DIM = MAT_DIM
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  advance,
  output logic [MAT_ADDR_W-1:0] row,
  output logic [MAT_ADDR_W-1:0] col,
  output logic                  last
);

  localparam logic [MAT_ADDR_W-1:0] MAX_IDX = MAT_ADDR_W'(DIM - 1);

  // Final element is always (DIM-1, DIM-1) regardless of scan order.
  assign last = (row == MAX_IDX) && (col == MAX_IDX);

  // Index register: clear to origin, or step to the next element.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row <= '0;
      col <= '0;
    end else if (clear) begin
      row <= '0;
      col <= '0;
    end else if (advance) begin
`ifdef MATRIX_COLMAJOR_EN
      if (row == MAX_IDX) begin
        row <= '0;
        col <= (col == MAX_IDX) ? '0 : col + 1'b1;
      end else begin
        row <= row + 1'b1;
      end
`else
      if (col == MAX_IDX) begin
        col <= '0;
        row <= (row == MAX_IDX) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
`endif
    end
  end

endmodule

// File: rtl/matrix_stream_reader.sv
// Scans a DIM x DIM matrix memory one element at a time and presents each
// element on a valid/ready stream with its coordinates.
// Build option: MATRIX_COLMAJOR_EN (column-major scan, see matrix_addr_counter).
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for start
// ISSUE   | en_ReadMat high for one cycle at the current index
// CAPTURE | memory data arrives; register it into the output stage
// HOLD    | out_valid high, waiting for out_ready
// DONE    | one-cycle done pulse, then back to IDLE
import matrix_pkg::*;

module matrix_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int DIM        = MAT_DIM
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  en_ReadMat,
  output logic                  en_WriteMat,
  output logic [MAT_ADDR_W-1:0] rowAddr,
  output logic [MAT_ADDR_W-1:0] colAddr,
  input  logic [DATA_WIDTH-1:0] readData,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [MAT_ADDR_W-1:0] out_row,
  output logic [MAT_ADDR_W-1:0] out_col,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last
);

  state_t state;
  logic   idx_clear;
  logic   idx_advance;
  logic   idx_last;

  // The reader only ever reads the matrix.
  assign en_WriteMat = 1'b0;

  // Index moves on the edge that leaves IDLE/DONE or accepts a non-final
  // element, so the address is already correct during the following ISSUE.
  assign idx_clear   = ((state == IDLE) && start) || (state == DONE);
  assign idx_advance = (state == HOLD) && out_ready && !idx_last;

  matrix_addr_counter #(
    .DIM (DIM)
  ) u_addr (
    .clk     (clk),
    .rst     (rst),
    .clear   (idx_clear),
    .advance (idx_advance),
    .row     (rowAddr),
    .col     (colAddr),
    .last    (idx_last)
  );

  // Scan sequencer with registered control and stream outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      en_ReadMat <= 1'b0;
      out_data   <= '0;
      out_row    <= '0;
      out_col    <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
    end else begin
      en_ReadMat <= 1'b0;
      done       <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state      <= ISSUE;
            busy       <= 1'b1;
            en_ReadMat <= 1'b1;
          end
        end
        ISSUE: begin
          state <= CAPTURE;
        end
        CAPTURE: begin
          out_data  <= readData;
          out_row   <= rowAddr;
          out_col   <= colAddr;
          out_last  <= idx_last;
          out_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (idx_last) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state      <= ISSUE;
              en_ReadMat <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_stream_reader.sv
// Self-checking bench for matrix_stream_reader with a registered-read
// matrix memory model and an order/timing reference computed from indices.
module tb_matrix_stream_reader;

  localparam int DW  = 8;
  localparam int DIM = 10;
  localparam int N   = DIM * DIM;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          busy, done, en_ReadMat, en_WriteMat;
  logic [3:0]    rowAddr, colAddr, out_row, out_col;
  logic [DW-1:0] readData = '0;
  logic [DW-1:0] out_data;
  logic          out_valid, out_last;
  logic          out_ready = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] mem [16][16];
  int exp_idx    = 0;
  int done_count = 0;
  int rd_count   = 0;
  bit done_due   = 0;
  bit rd_prev    = 0;
  int ready_mode = 0;

  matrix_stream_reader #(.DATA_WIDTH(DW), .DIM(DIM)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .en_ReadMat  (en_ReadMat),
    .en_WriteMat (en_WriteMat),
    .rowAddr     (rowAddr),
    .colAddr     (colAddr),
    .readData    (readData),
    .out_data    (out_data),
    .out_row     (out_row),
    .out_col     (out_col),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_last    (out_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Scan order: k-th element's coordinates.
  function automatic int exp_r(input int k);
`ifdef MATRIX_COLMAJOR_EN
    return k % DIM;
`else
    return k / DIM;
`endif
  endfunction

  function automatic int exp_c(input int k);
`ifdef MATRIX_COLMAJOR_EN
    return k / DIM;
`else
    return k % DIM;
`endif
  endfunction

  // Memory: data valid the cycle after the read-enable edge.
  always @(posedge clk) if (en_ReadMat) readData <= mem[rowAddr][colAddr];

  // Downstream ready pattern.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      2:       out_ready = 1'b0;
      default: out_ready = (exp_idx != 57);
    endcase
  end

  // Stream monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      bit last_xfer;
      int r, c;
      last_xfer = 0;
      check("wr_en_zero", en_WriteMat, 0);
      check("addr_in_range", (rowAddr < DIM) && (colAddr < DIM), 1);
      if (en_ReadMat) begin
        check("rd_single_cycle", rd_prev, 0);
        rd_count++;
      end
      rd_prev = en_ReadMat;
      check("done_pulse", done, done_due);
      if (done) done_count++;
      if (out_valid) begin
        if (exp_idx >= N) begin
          check("overrun", out_valid, 0);
        end else begin
          r = exp_r(exp_idx);
          c = exp_c(exp_idx);
          check("out_data", out_data, mem[r][c]);
          check("out_row", out_row, r);
          check("out_col", out_col, c);
          check("out_last", out_last, (r == DIM-1) && (c == DIM-1));
          if (out_ready) begin
            if (exp_idx == N-1) last_xfer = 1;
            exp_idx++;
          end
        end
      end
      done_due = last_xfer;
    end
  end

  task automatic model_clear();
    exp_idx    = 0;
    done_count = 0;
    rd_count   = 0;
    done_due   = 0;
    rd_prev    = 0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_rd"}, en_ReadMat, 0);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_last"}, out_last, 0);
    check({tag, "_data"}, out_data, 0);
    check({tag, "_orow"}, out_row, 0);
    check({tag, "_ocol"}, out_col, 0);
    check({tag, "_raddr"}, rowAddr, 0);
    check({tag, "_caddr"}, colAddr, 0);
  endtask

  task automatic run_scan(input int mode, input bit inject_restart);
    int first;
    int n;
    bit injected;
    model_clear();
    ready_mode = mode;
    first = -1;
    injected = 0;
    @(posedge clk); #1;
    start = 1'b1;
    for (n = 1; n <= 5000; n++) begin
      @(posedge clk); #1;
      if (start) start = 1'b0;
      if (out_valid && first < 0) first = n;
      if (inject_restart && !injected && exp_idx >= 40) begin
        start = 1'b1;
        injected = 1;
      end
      if (done) break;
    end
    start = 1'b0;
    check("done_seen", done, 1);
    if (mode == 0) begin
      check("first_valid_latency", first, 3);
      check("scan_cycles", n, 3 * N + 1);
    end
    repeat (4) @(posedge clk);
    #1;
    check("xfer_count", exp_idx, N);
    check("done_count", done_count, 1);
    check("rd_count", rd_count, N);
    check("idle_after_scan", busy, 0);
  endtask

  initial begin
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++)
        mem[r][c] = DW'(r * 10 + c);

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    check("reset_wr", en_WriteMat, 0);
    @(negedge clk);
    rst = 1'b0;

    // Full scan, ready always high.
    run_scan(0, 0);
    // Same data, random backpressure.
    run_scan(1, 0);
    // Random matrix contents, random backpressure.
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++)
        mem[r][c] = DW'($urandom);
    run_scan(1, 0);
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++)
        mem[r][c] = DW'(r * 10 + c);
    // start mid-scan is ignored.
    run_scan(0, 1);
    run_scan(1, 1);

    // Abort with reset while holding element 57.
    begin
      model_clear();
      ready_mode = 3;
      @(posedge clk); #1;
      start = 1'b1;
      for (int n = 0; n < 2000; n++) begin
        @(posedge clk); #1;
        start = 1'b0;
        if (out_valid && exp_idx == 57) break;
      end
      check("abort_reached", exp_idx, 57);
      check("abort_holding", out_valid, 1);
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      rst = 1'b1;
      #1;
      check_idle_outputs("async_rst");
      repeat (3) @(posedge clk);
      #1;
      check("abort_no_done", done_count, 0);
      @(negedge clk);
      rst = 1'b0;
    end
    run_scan(0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
